wb_bus_initiator: RTL and testbench
===================================

# wb_bus_initiator

Single-outstanding Wishbone pipelined-mode initiator that converts a valid/ready command stream into bus cycles toward on-chip peripherals such as the UART register block. It sits between a command source (debug bridge, DMA sequencer or test controller) and the 5-bit/8-bit peripheral bus. Each command returns exactly one response carrying read data or a timeout error.

## Interface
- ADDR_W, 5, bus address width
- DATA_W, 8, bus data width
- TIMEOUT, 255, cycles allowed from strobe assertion to ack; 0 disables timeout
---
- wb_clk_i  input  1  bus clock; all logic on rising edge
- wb_reset_n_i  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- req_valid_i  input  1  command present
- req_ready_o  output  1  initiator can accept command
- req_write_i  input  1  1 = write, 0 = read
- req_addr_i  input  ADDR_W  command address
- req_data_i  input  DATA_W  write data
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  consumer takes response
- rsp_data_o  output  DATA_W  read data; 0 for writes and errors
- rsp_err_o  output  1  1 = bus timeout
- wb_cyc_o  output  1  bus cycle active
- wb_strobe_o  output  1  transaction valid
- wb_write_o  output  1  write enable
- wb_addr_o  output  ADDR_W  address
- wb_data_o  output  DATA_W  write data
- wb_data_i  input  DATA_W  read data
- wb_ack_i  input  1  responder ack
- wb_stall_i  input  1  responder stall

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RESP.
- IDLE: req_ready_o=1. On edge with req_valid_i: latch write/addr/data into wb_write_o/wb_addr_o/wb_data_o, clear timeout counter, go to REQ.
- REQ: wb_cyc_o=1, wb_strobe_o=1. Edge with !wb_stall_i: strobe accepted, go to WAIT_ACK. Stall holds REQ with all bus outputs stable.
- WAIT_ACK: wb_cyc_o=1, wb_strobe_o=0. Edge with wb_ack_i: capture wb_data_i (reads only; writes capture 0), rsp_err_o=0, go to RESP.
- RESP: wb_cyc_o=0, rsp_valid_o=1; data/err held stable until edge with rsp_ready_i, then IDLE.
- Timeout: counter width $clog2(TIMEOUT+1); increments every cycle in REQ or WAIT_ACK. Edge where counter==TIMEOUT-1 without qualifying ack: go to RESP with rsp_err_o=1, rsp_data_o=0, cyc dropped. Ack and timeout on same edge: ack wins. TIMEOUT=0: never times out.
- wb_ack_i in IDLE, REQ or RESP ignored (no state change).
- req_valid_i while not IDLE ignored; req_ready_o=0.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, wb_cyc_o=0, wb_strobe_o=0, wb_write_o=0, wb_addr_o=0, wb_data_o=0; state IDLE.
- Reset mid-transaction: cyc/strobe drop asynchronously; pending response lost.
- Command accepted at edge k: strobe high cycle k+1. With zero stall and registered ack (responder acks cycle after strobe), ack seen at edge k+2, rsp_valid_o high from k+3.
- Minimum 4 cycles per command with rsp_ready_i held high; no overlap.
- All outputs registered or decoded from state only; no combinational path from any input to any output.

## Structure
- Shared package wb_pkg: wb_init_state_t enum (IDLE, REQ, WAIT_ACK, RESP), default ADDR_W/DATA_W constants.
- Single module; no sub-module warranted (counter is inline).

## Test plan
- Write addr 5'h1 data 8'hA5, stall=0, ack one cycle after strobe -> one strobe cycle, wb_write_o=1, wb_data_o=8'hA5, rsp_valid_o at k+3, rsp_err_o=0, rsp_data_o=0.
- Read addr 5'h4, responder returns 8'h04 -> rsp_data_o=8'h04, rsp_err_o=0; wb_cyc_o low in RESP.
- Read with wb_stall_i high 3 cycles -> strobe held 4 cycles, address stable, exactly one ack consumed, correct data.
- TIMEOUT=8, no ack -> wb_cyc_o high exactly 8 cycles, rsp_err_o=1, rsp_data_o=0; ack arriving at timeout edge instead -> rsp_err_o=0.
- rsp_ready_i low 5 cycles -> response held, req_ready_o=0, new req_valid_i ignored; release -> IDLE next cycle.
- Assert wb_reset_n_i during WAIT_ACK -> wb_cyc_o=0 immediately, all outputs at reset values; stray ack after reset produces no response.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the Wishbone bus initiator.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        RESP
    } wb_init_state_t;

    localparam int WB_ADDR_W  = 5;
    localparam int WB_DATA_W  = 8;
    localparam int WB_TIMEOUT = 255;

    // Width of the timeout counter; a disabled timeout still keeps one bit.
    function automatic int wb_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_bus_initiator.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus
// cycle out, one response (read data or timeout error) back.
module wb_bus_initiator
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = WB_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              wb_cyc_o,
    output logic              wb_strobe_o,
    output logic              wb_write_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i
);

    localparam int              CNT_W   = wb_cnt_width(TIMEOUT);
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    wb_init_state_t    state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              timeout_hit;

    assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        write_reg <= req_write_i;
                        addr_reg  <= req_addr_i;
                        data_reg  <= req_data_i;
                        cnt_reg   <= '0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A stalled strobe can still expire; expiry beats acceptance.
                    if (timeout_hit) begin
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                        state_reg    <= RESP;
                    end else if (!wb_stall_i) begin
                        state_reg <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (wb_ack_i) begin
                        rsp_data_reg <= write_reg ? '0 : wb_data_i;
                        rsp_err_reg  <= 1'b0;
                        state_reg    <= RESP;
                    end else if (timeout_hit) begin
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                        state_reg    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Handshake and bus-cycle strobes are pure state decodes so reset drops them at once.
    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign wb_cyc_o    = (state_reg == REQ) || (state_reg == WAIT_ACK);
    assign wb_strobe_o = (state_reg == REQ);
    assign wb_write_o  = write_reg;
    assign wb_addr_o   = addr_reg;
    assign wb_data_o   = data_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_wb_bus_initiator.sv
// Scoreboard bench for wb_bus_initiator with a small Wishbone responder model.
module tb_wb_bus_initiator;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready_o;
    logic       req_write;
    logic [4:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid_o;
    logic       rsp_ready;
    logic [7:0] rsp_data_o;
    logic       rsp_err_o;
    logic       wb_cyc_o;
    logic       wb_strobe_o;
    logic       wb_write_o;
    logic [4:0] wb_addr_o;
    logic [7:0] wb_data_o;
    logic [7:0] wb_rdata;
    logic       wb_ack;
    logic       wb_stall;

    int n_vec  = 0;
    int n_fail = 0;

    logic [8:0] exp_q[$];
    logic [7:0] mem [32];

    bit         resp_en   = 1'b1;
    int         ack_delay = 0;

    wb_bus_initiator #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(8)) dut (
        .wb_clk_i     (clk),
        .wb_reset_n_i (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_strobe_o  (wb_strobe_o),
        .wb_write_o   (wb_write_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .wb_data_i    (wb_rdata),
        .wb_ack_i     (wb_ack),
        .wb_stall_i   (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: acks ack_delay+1 cycles after an accepted strobe.
    always @(posedge clk) begin
        logic       acc;
        logic [4:0] acc_addr;
        bit         pend;
        int         cd;
        acc      = wb_strobe_o && !wb_stall && resp_en;
        acc_addr = wb_addr_o;
        if (acc && wb_write_o) mem[acc_addr] = wb_data_o;
        #1;
        wb_ack   = 1'b0;
        wb_rdata = 8'h00;
        if (acc) begin
            pend = 1'b1;
            cd   = ack_delay;
        end
        if (pend) begin
            if (cd == 0) begin
                wb_ack   = 1'b1;
                wb_rdata = mem[acc_addr];
                pend     = 1'b0;
            end else begin
                cd--;
            end
        end
    end

    // Monitor: every consumed response is compared against the scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && rsp_valid_o && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL stray_rsp: got err=%0b data=%0h expected no response", rsp_err_o, rsp_data_o);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[8]});
                check("rsp_data", {24'd0, rsp_data_o}, {24'd0, e[7:0]});
                $display("rsp: err=%0b data=%02h", rsp_err_o, rsp_data_o);
            end
        end
    end

    task automatic run_cmd(input logic w, input logic [4:0] a, input logic [7:0] d,
                           input logic eerr, input logic [7:0] edata,
                           input int stall_cycles, input int hold_cycles,
                           output int strb, output int cyc, output int first_rsp);
        bit done;
        int held;
        strb = 0; cyc = 0; first_rsp = 0; done = 1'b0; held = 0;
        @(posedge clk); #1;
        wb_stall  = (stall_cycles > 0);
        rsp_ready = (hold_cycles == 0);
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        exp_q.push_back({eerr, edata});
        $display("cmd: %s addr=%02h data=%02h", w ? "WR" : "RD", a, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (wb_strobe_o) begin
                strb++;
                check("strb_addr", {27'd0, wb_addr_o}, {27'd0, a});
                check("strb_write", {31'd0, wb_write_o}, {31'd0, w});
                if (w) check("strb_wdata", {24'd0, wb_data_o}, {24'd0, d});
            end
            if (wb_cyc_o) cyc++;
            if (rsp_valid_o) begin
                if (first_rsp == 0) first_rsp = i;
                check("cyc_in_resp", {31'd0, wb_cyc_o}, 32'd0);
                if (rsp_ready) done = 1'b1;
                else begin
                    held++;
                    check("ready_in_resp", {31'd0, req_ready_o}, 32'd0);
                    check("rsp_held", {24'd0, rsp_data_o}, {24'd0, edata});
                end
            end
            @(posedge clk); #1;
            if (stall_cycles > 0 && i == stall_cycles) wb_stall = 1'b0;
            if (held > 0 && !rsp_ready) begin
                if (held >= hold_cycles) begin
                    rsp_ready = 1'b1; req_valid = 1'b0;
                end else begin
                    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h09; req_data = 8'hEE;
                end
            end
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL rsp_timeout: got no response expected one within 40 cycles");
        end
    endtask

    initial begin
        int strb, cyc, first, bad;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b1; wb_ack = 1'b0; wb_rdata = '0; wb_stall = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[4] = 8'h04; mem[2] = 8'h3C; mem[6] = 8'hC3;

        #12;
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_outs", {rsp_valid_o, rsp_err_o, wb_cyc_o, wb_strobe_o, wb_write_o}, 32'd0);
        check("rst_data", {rsp_data_o, wb_addr_o, wb_data_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Write: one strobe, response on the third cycle after acceptance.
        run_cmd(1'b1, 5'h01, 8'hA5, 1'b0, 8'h00, 0, 0, strb, cyc, first);
        check("wr_strb", strb, 1);
        check("wr_cyc", cyc, 2);
        check("wr_latency", first, 3);

        run_cmd(1'b0, 5'h04, 8'h00, 1'b0, 8'h04, 0, 0, strb, cyc, first);
        check("rd_latency", first, 3);
        run_cmd(1'b0, 5'h01, 8'h00, 1'b0, 8'hA5, 0, 0, strb, cyc, first);

        // Stall for three edges: strobe lasts four cycles.
        run_cmd(1'b0, 5'h02, 8'h00, 1'b0, 8'h3C, 3, 0, strb, cyc, first);
        check("stall_strb", strb, 4);
        check("stall_latency", first, 6);

        // No ack: cycle drops after exactly TIMEOUT cycles.
        resp_en = 1'b0;
        run_cmd(1'b0, 5'h07, 8'h00, 1'b1, 8'h00, 0, 0, strb, cyc, first);
        check("to_cyc", cyc, 8);
        check("to_latency", first, 9);
        resp_en = 1'b1;

        // Ack on the expiry edge wins over the timeout.
        ack_delay = 6;
        run_cmd(1'b0, 5'h06, 8'h00, 1'b0, 8'hC3, 0, 0, strb, cyc, first);
        check("ackto_cyc", cyc, 8);
        ack_delay = 0;

        // Consumer back-pressure: response held, new command ignored.
        run_cmd(1'b0, 5'h04, 8'h00, 1'b0, 8'h04, 0, 5, strb, cyc, first);
        @(negedge clk);
        check("idle_after_rsp", {31'd0, req_ready_o}, 32'd1);
        check("ignored_req", {31'd0, wb_cyc_o}, 32'd0);

        // Reset during WAIT_ACK with an ack still in flight.
        ack_delay = 4;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h03; req_data = 8'h5A;
        $display("cmd: WR addr=03 data=5a (reset during WAIT_ACK)");
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_wait", {wb_cyc_o, wb_strobe_o}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("arst_outs", {req_ready_o, rsp_valid_o, rsp_err_o, wb_strobe_o, wb_write_o}, 32'h10);
        check("arst_data", {rsp_data_o, wb_addr_o, wb_data_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid_o || wb_cyc_o) bad++;
        end
        check("stray_ack", bad, 0);
        ack_delay = 0;

        run_cmd(1'b0, 5'h04, 8'h00, 1'b0, 8'h04, 0, 0, strb, cyc, first);
        check("post_rst_latency", first, 3);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

endmodule
